switch_port_endpoint: RTL

- Host-side endpoint that sits on the outside of one 4-port switch port.
- TX path: queues local packet requests and drives the port's *_in signals (valid/source/target/data) with configurable inter-packet pacing.
- RX path: samples the port's *_out signals every cycle, filters by destination ID, and buffers packets for a local consumer with ready/valid. Also keeps misroute and drop counters.
- Used as the traffic source/sink attached to each switch port in system-level simulation and on the FPGA test harness.

---
 rtl/switch_port_endpoint.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/switch_port_endpoint.sv
// Host-side endpoint for one switch port: paced TX queue toward the switch,
// destination-filtered RX queue toward a local consumer, plus misroute/drop counters.
module switch_port_endpoint #(
  parameter int PORT_ID  = 0,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int MIN_GAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [ADDR_W-1:0] tx_target,
  input  logic [DATA_W-1:0] tx_data,
  output logic              sw_valid_in,
  output logic [ADDR_W-1:0] sw_source_in,
  output logic [ADDR_W-1:0] sw_target_in,
  output logic [DATA_W-1:0] sw_data_in,
  input  logic              sw_valid_out,
  input  logic [ADDR_W-1:0] sw_source_out,
  input  logic [ADDR_W-1:0] sw_target_out,
  input  logic [DATA_W-1:0] sw_data_out,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] rx_source,
  output logic [DATA_W-1:0] rx_data,
  output logic [7:0]        misroute_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [ADDR_W-1:0] MY_ADDR  = ADDR_W'(PORT_ID);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

  // ---------------- TX FIFO ----------------
  logic [ADDR_W-1:0] tx_tgt_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] tx_dat_mem_q [TX_DEPTH];
  logic [TX_AW:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic              tx_full, tx_empty, tx_push, tx_pop;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                    (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;

  always_comb begin
    tx_wr_d = tx_wr_q + {{TX_AW{1'b0}}, tx_push};
    tx_rd_d = tx_rd_q + {{TX_AW{1'b0}}, tx_pop};
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_tgt_mem_q[tx_wr_q[TX_AW-1:0]] <= tx_target;
      tx_dat_mem_q[tx_wr_q[TX_AW-1:0]] <= tx_data;
    end
  end

  // ---------------- TX FSM ----------------
  logic [1:0]        state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sw_valid_q, sw_valid_d;
  logic [ADDR_W-1:0] sw_source_q, sw_source_d;
  logic [ADDR_W-1:0] sw_target_q, sw_target_d;
  logic [DATA_W-1:0] sw_data_q, sw_data_d;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    tx_pop      = 1'b0;
    sw_valid_d  = 1'b0;
    sw_source_d = sw_source_q;
    sw_target_d = sw_target_q;
    sw_data_d   = sw_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (MIN_GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (!tx_empty) begin
          tx_pop = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_ONE) begin
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Target/data are only refreshed on a pop so they hold between pulses.
    if (tx_pop) begin
      sw_valid_d  = 1'b1;
      sw_source_d = MY_ADDR;
      sw_target_d = tx_tgt_mem_q[tx_rd_q[TX_AW-1:0]];
      sw_data_d   = tx_dat_mem_q[tx_rd_q[TX_AW-1:0]];
    end
  end

  assign sw_valid_in  = sw_valid_q;
  assign sw_source_in = sw_source_q;
  assign sw_target_in = sw_target_q;
  assign sw_data_in   = sw_data_q;

  // ---------------- RX FIFO ----------------
  logic [ADDR_W-1:0] rx_src_mem_q [RX_DEPTH];
  logic [DATA_W-1:0] rx_dat_mem_q [RX_DEPTH];
  logic [RX_AW:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic              rx_full, rx_empty, rx_push, rx_pop, rx_match;
  logic [ADDR_W-1:0] rx_src_q, rx_src_d;
  logic [DATA_W-1:0] rx_dat_q, rx_dat_d;
  logic [7:0]        mis_q, mis_d, drop_q, drop_d;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign rx_match = sw_valid_out && (sw_target_out == MY_ADDR);
  assign rx_pop   = !rx_empty && rx_ready;
  assign rx_push  = rx_match && (!rx_full || rx_pop);

  always_comb begin
    rx_wr_d = rx_wr_q + {{RX_AW{1'b0}}, rx_push};
    rx_rd_d = rx_rd_q + {{RX_AW{1'b0}}, rx_pop};
    mis_d   = mis_q;
    drop_d  = drop_q;
    if (sw_valid_out && !rx_match && (mis_q != 8'hFF)) mis_d = mis_q + 8'd1;
    if (rx_match && rx_full && !rx_pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Head registers track the next head; the incoming packet bypasses memory
  // when it lands in the slot that becomes the head.
  always_comb begin
    rx_src_d = rx_src_q;
    rx_dat_d = rx_dat_q;
    if (rx_wr_d != rx_rd_d) begin
      if (rx_push && (rx_wr_q[RX_AW-1:0] == rx_rd_d[RX_AW-1:0])) begin
        rx_src_d = sw_source_out;
        rx_dat_d = sw_data_out;
      end else begin
        rx_src_d = rx_src_mem_q[rx_rd_d[RX_AW-1:0]];
        rx_dat_d = rx_dat_mem_q[rx_rd_d[RX_AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_src_mem_q[rx_wr_q[RX_AW-1:0]] <= sw_source_out;
      rx_dat_mem_q[rx_wr_q[RX_AW-1:0]] <= sw_data_out;
    end
  end

  assign rx_valid     = !rx_empty;
  assign rx_source    = rx_src_q;
  assign rx_data      = rx_dat_q;
  assign misroute_cnt = mis_q;
  assign drop_cnt     = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      sw_valid_q  <= 1'b0;
      sw_source_q <= '0;
      sw_target_q <= '0;
      sw_data_q   <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_src_q    <= '0;
      rx_dat_q    <= '0;
      mis_q       <= '0;
      drop_q      <= '0;
    end else begin
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      sw_valid_q  <= sw_valid_d;
      sw_source_q <= sw_source_d;
      sw_target_q <= sw_target_d;
      sw_data_q   <= sw_data_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      rx_src_q    <= rx_src_d;
      rx_dat_q    <= rx_dat_d;
      mis_q       <= mis_d;
      drop_q      <= drop_d;
    end
  end

endmodule
